// File: rtl/tl_buffer_param.sv
// TileLink A/D channel buffer: an independent circular queue per channel; depth 0 degenerates to wires.
// Define TLBUF_OCC_EN to add the a_count/d_count occupancy outputs.

module tl_buffer_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  parameter bit PIPE  = 1'b0,
  parameter bit FLOW  = 1'b0,
  parameter int CNT_W = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef TLBUF_OCC_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  if (DEPTH == 0) begin : g_wire
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
`ifdef TLBUF_OCC_EN
    assign count = '0;
`endif
  end else begin : g_queue
    localparam int PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam int MEM_N = 1 << PTR_W;

    logic [W-1:0]     mem [MEM_N];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             empty;
    logic             full;
    logic             enq;
    logic             deq;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_W'(DEPTH));
    assign in_ready  = !full || (PIPE && out_ready);
    assign out_valid = !empty || (FLOW && in_valid);
    assign out_data  = (FLOW && empty) ? in_data : mem[rd_ptr];
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    // a flow-through beat consumed on arrival never touches the store
    assign do_wr     = enq && !(FLOW && empty && out_ready);
    assign do_rd     = deq && !empty;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
        if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
        if (do_wr && !do_rd)      cnt <= cnt + CNT_W'(1);
        else if (do_rd && !do_wr) cnt <= cnt - CNT_W'(1);
      end
    end

    // payload store is never reset; only the pointers and count define validity
    always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= in_data;
    end

`ifdef TLBUF_OCC_EN
    assign count = cnt;
`endif
  end

endmodule

module tl_buffer_param #(
  parameter int A_DEPTH  = 2,
  parameter int D_DEPTH  = 2,
  parameter int PIPE     = 0,
  parameter int FLOW     = 0,
  parameter int SOURCE_W = 7,
  parameter int ADDR_W   = 31,
  parameter int DATA_W   = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                auto_in_a_valid,
  output logic                auto_in_a_ready,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [1:0]          auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  output logic                auto_out_a_valid,
  input  logic                auto_out_a_ready,
  output logic [2:0]          auto_out_a_bits_opcode,
  output logic [2:0]          auto_out_a_bits_param,
  output logic [1:0]          auto_out_a_bits_size,
  output logic [SOURCE_W-1:0] auto_out_a_bits_source,
  output logic [ADDR_W-1:0]   auto_out_a_bits_address,
  output logic [DATA_W/8-1:0] auto_out_a_bits_mask,
  output logic [DATA_W-1:0]   auto_out_a_bits_data,
  output logic                auto_out_a_bits_corrupt,
  input  logic                auto_out_d_valid,
  output logic                auto_out_d_ready,
  input  logic [2:0]          auto_out_d_bits_opcode,
  input  logic [1:0]          auto_out_d_bits_size,
  input  logic [SOURCE_W-1:0] auto_out_d_bits_source,
  input  logic [DATA_W-1:0]   auto_out_d_bits_data,
  output logic                auto_in_d_valid,
  input  logic                auto_in_d_ready,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [1:0]          auto_in_d_bits_size,
  output logic [SOURCE_W-1:0] auto_in_d_bits_source,
  output logic [DATA_W-1:0]   auto_in_d_bits_data
`ifdef TLBUF_OCC_EN
  ,
  output logic [((A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1))-1:0] a_count,
  output logic [((D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1))-1:0] d_count
`endif
);

  localparam int A_W = 3 + 3 + 2 + SOURCE_W + ADDR_W + DATA_W / 8 + DATA_W + 1;
  localparam int D_W = 3 + 2 + SOURCE_W + DATA_W;

  logic [A_W-1:0] a_in;
  logic [A_W-1:0] a_out;
  logic [D_W-1:0] d_in;
  logic [D_W-1:0] d_out;

  assign a_in = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                 auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                 auto_in_a_bits_data, auto_in_a_bits_corrupt};
  assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
          auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
          auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_out;

  assign d_in = {auto_out_d_bits_opcode, auto_out_d_bits_size,
                 auto_out_d_bits_source, auto_out_d_bits_data};
  assign {auto_in_d_bits_opcode, auto_in_d_bits_size,
          auto_in_d_bits_source, auto_in_d_bits_data} = d_out;

  tl_buffer_queue #(
    .DEPTH(A_DEPTH), .W(A_W), .PIPE(PIPE != 0), .FLOW(FLOW != 0)
  ) u_a_queue (
    .clock     (clock),
    .reset     (reset),
`ifdef TLBUF_OCC_EN
    .count     (a_count),
`endif
    .in_valid  (auto_in_a_valid),
    .in_ready  (auto_in_a_ready),
    .in_data   (a_in),
    .out_valid (auto_out_a_valid),
    .out_ready (auto_out_a_ready),
    .out_data  (a_out)
  );

  tl_buffer_queue #(
    .DEPTH(D_DEPTH), .W(D_W), .PIPE(PIPE != 0), .FLOW(FLOW != 0)
  ) u_d_queue (
    .clock     (clock),
    .reset     (reset),
`ifdef TLBUF_OCC_EN
    .count     (d_count),
`endif
    .in_valid  (auto_out_d_valid),
    .in_ready  (auto_out_d_ready),
    .in_data   (d_in),
    .out_valid (auto_in_d_valid),
    .out_ready (auto_in_d_ready),
    .out_data  (d_out)
  );

endmodule

// File: tb/tb_tl_buffer_param.sv
// Bench for tl_buffer_param: four configurations share one stimulus bus, each checked in turn.
// Instances: 0 = depth 2/2 PIPE, 1 = depth 3/3, 2 = depth 1/1 FLOW, 3 = depth 0/0 wires.

module tb_tl_buffer_param;

  logic clock;
  logic reset;

  logic        a_valid, a_corrupt, oa_ready;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [6:0]  a_source;
  logic [30:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_valid, id_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [6:0]  d_source;
  logic [63:0] d_data;

  logic        ia_ready [4];
  logic        oa_valid [4];
  logic [2:0]  oa_opcode [4];
  logic [2:0]  oa_param [4];
  logic [1:0]  oa_size [4];
  logic [6:0]  oa_source [4];
  logic [30:0] oa_address [4];
  logic [7:0]  oa_mask [4];
  logic [63:0] oa_data [4];
  logic        oa_corrupt [4];
  logic        od_ready [4];
  logic        id_valid [4];
  logic [2:0]  id_opcode [4];
  logic [1:0]  id_size [4];
  logic [6:0]  id_source [4];
  logic [63:0] id_data [4];
`ifdef TLBUF_OCC_EN
  logic [3:0]  a_cnt [4];
  logic [3:0]  d_cnt [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DEP = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 0;
`ifdef TLBUF_OCC_EN
    localparam int CW = (DEP == 0) ? 1 : $clog2(DEP + 1);
    logic [CW-1:0] ac;
    logic [CW-1:0] dc;
    assign a_cnt[g] = 4'(ac);
    assign d_cnt[g] = 4'(dc);
`endif
    tl_buffer_param #(
      .A_DEPTH(DEP), .D_DEPTH(DEP), .PIPE((g == 0) ? 1 : 0), .FLOW((g == 2) ? 1 : 0),
      .SOURCE_W(7), .ADDR_W(31), .DATA_W(64)
    ) u_dut (
      .clock                   (clock),
      .reset                   (reset),
      .auto_in_a_valid         (a_valid),
      .auto_in_a_ready         (ia_ready[g]),
      .auto_in_a_bits_opcode   (a_opcode),
      .auto_in_a_bits_param    (a_param),
      .auto_in_a_bits_size     (a_size),
      .auto_in_a_bits_source   (a_source),
      .auto_in_a_bits_address  (a_address),
      .auto_in_a_bits_mask     (a_mask),
      .auto_in_a_bits_data     (a_data),
      .auto_in_a_bits_corrupt  (a_corrupt),
      .auto_out_a_valid        (oa_valid[g]),
      .auto_out_a_ready        (oa_ready),
      .auto_out_a_bits_opcode  (oa_opcode[g]),
      .auto_out_a_bits_param   (oa_param[g]),
      .auto_out_a_bits_size    (oa_size[g]),
      .auto_out_a_bits_source  (oa_source[g]),
      .auto_out_a_bits_address (oa_address[g]),
      .auto_out_a_bits_mask    (oa_mask[g]),
      .auto_out_a_bits_data    (oa_data[g]),
      .auto_out_a_bits_corrupt (oa_corrupt[g]),
      .auto_out_d_valid        (d_valid),
      .auto_out_d_ready        (od_ready[g]),
      .auto_out_d_bits_opcode  (d_opcode),
      .auto_out_d_bits_size    (d_size),
      .auto_out_d_bits_source  (d_source),
      .auto_out_d_bits_data    (d_data),
      .auto_in_d_valid         (id_valid[g]),
      .auto_in_d_ready         (id_ready),
      .auto_in_d_bits_opcode   (id_opcode[g]),
      .auto_in_d_bits_size     (id_size[g]),
      .auto_in_d_bits_source   (id_source[g]),
`ifdef TLBUF_OCC_EN
      .a_count                 (ac),
      .d_count                 (dc),
`endif
      .auto_in_d_bits_data     (id_data[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       a_v;
    logic [6:0] a_src;
    logic       oa_rdy;
    logic       d_v;
    logic [6:0] d_src;
    logic       id_rdy;
    logic       e_ia_rdy;
    logic       e_oa_v;
    logic [6:0] e_oa_src;
    logic       e_od_rdy;
    logic       e_id_v;
    logic [6:0] e_id_src;
    logic [3:0] e_a_cnt;
    logic [3:0] e_d_cnt;
  } vec_t;

  vec_t  t_wire [4];
  vec_t  t_fill [6];
  int    n_chk  = 0;
  int    n_fail = 0;
  string ctx    = "init";

  function automatic logic [30:0] addr_of(input logic [6:0] s);
    return {s, 17'h1A5A5, s};
  endfunction

  function automatic logic [63:0] pay(input logic [6:0] s);
    return {s, 25'h0ABCDEF, s, 25'h1234567};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s actual=%0h required=%0h", ctx, nm, act, exp);
    end
  endtask

  task automatic set_a(input logic v, input logic [6:0] s);
    a_valid   = v;
    a_opcode  = s[2:0];
    a_param   = s[6:4];
    a_size    = s[1:0];
    a_source  = s;
    a_address = addr_of(s);
    a_mask    = {s[0], s};
    a_data    = pay(s);
    a_corrupt = s[0];
  endtask

  task automatic set_d(input logic v, input logic [6:0] s);
    d_valid  = v;
    d_opcode = s[2:0];
    d_size   = s[1:0];
    d_source = s;
    d_data   = ~pay(s);
  endtask

  task automatic idle_inputs();
    set_a(1'b0, 7'h00);
    set_d(1'b0, 7'h00);
    oa_ready = 1'b0;
    id_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic chk_cnt(input int k, input logic [3:0] ea, input logic [3:0] ed);
`ifdef TLBUF_OCC_EN
    chk("a_count", a_cnt[k], ea);
    chk("d_count", d_cnt[k], ed);
`endif
  endtask

  task automatic apply_vec(input int k, input vec_t v);
    set_a(v.a_v, v.a_src);
    oa_ready = v.oa_rdy;
    set_d(v.d_v, v.d_src);
    id_ready = v.id_rdy;
    @(negedge clock);
    chk("in_a_ready", ia_ready[k], v.e_ia_rdy);
    chk("out_a_valid", oa_valid[k], v.e_oa_v);
    if (v.e_oa_v) begin
      chk("out_a_source", oa_source[k], v.e_oa_src);
      chk("out_a_address", oa_address[k], addr_of(v.e_oa_src));
      chk("out_a_data", oa_data[k], pay(v.e_oa_src));
    end
    chk("out_d_ready", od_ready[k], v.e_od_rdy);
    chk("in_d_valid", id_valid[k], v.e_id_v);
    if (v.e_id_v) begin
      chk("in_d_source", id_source[k], v.e_id_src);
      chk("in_d_data", id_data[k], ~pay(v.e_id_src));
    end
    chk_cnt(k, v.e_a_cnt, v.e_d_cnt);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int sent;
    int rcv;
    int cyc;

    // depth-0 wires: a_v, a_src, oa_rdy, d_v, d_src, id_rdy | expected outputs
    t_wire[0] = '{1'b1, 7'h11, 1'b1, 1'b0, 7'h22, 1'b0, 1'b1, 1'b1, 7'h11, 1'b0, 1'b0, 7'h00, 4'd0, 4'd0};
    t_wire[1] = '{1'b0, 7'h00, 1'b0, 1'b1, 7'h33, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 7'h33, 4'd0, 4'd0};
    t_wire[2] = '{1'b1, 7'h7F, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 1'b1, 7'h7F, 1'b0, 1'b1, 7'h00, 4'd0, 4'd0};
    t_wire[3] = '{1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 4'd0, 4'd0};
    // depth-2 PIPE A queue: fill with 0x01, 0x02 while stalled, then drain in order
    t_fill[0] = '{1'b1, 7'h01, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 4'd0, 4'd0};
    t_fill[1] = '{1'b1, 7'h02, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h01, 1'b1, 1'b0, 7'h00, 4'd1, 4'd0};
    t_fill[2] = '{1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h01, 1'b1, 1'b0, 7'h00, 4'd2, 4'd0};
    t_fill[3] = '{1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h01, 1'b1, 1'b0, 7'h00, 4'd2, 4'd0};
    t_fill[4] = '{1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h02, 1'b1, 1'b0, 7'h00, 4'd1, 4'd0};
    t_fill[5] = '{1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 4'd0, 4'd0};

    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    ctx = "reset";
    for (int k = 0; k < 3; k++) begin
      chk("in_a_ready", ia_ready[k], 1'b1);
      chk("out_a_valid", oa_valid[k], 1'b0);
      chk("out_d_ready", od_ready[k], 1'b1);
      chk("in_d_valid", id_valid[k], 1'b0);
      chk_cnt(k, 4'd0, 4'd0);
    end
    step();
    reset = 1'b1;

    ctx = "wire";
    for (int i = 0; i < 4; i++) apply_vec(3, t_wire[i]);

    do_reset();
    ctx = "fill2";
    for (int i = 0; i < 6; i++) apply_vec(0, t_fill[i]);

    // full D queue with PIPE accepts while its head leaves
    do_reset();
    ctx = "pipe_d";
    set_d(1'b1, 7'h21);
    step();
    set_d(1'b1, 7'h22);
    step();
    set_d(1'b1, 7'h23);
    @(negedge clock);
    chk("full_ready_stalled", od_ready[0], 1'b0);
    chk("in_d_valid", id_valid[0], 1'b1);
    id_ready = 1'b1;
    #1;
    chk("full_ready_pipe", od_ready[0], 1'b1);
    chk("head_source", id_source[0], 7'h21);
    chk_cnt(0, 4'd0, 4'd2);
    step();
    set_d(1'b0, 7'h00);
    id_ready = 1'b0;
    @(negedge clock);
    chk("head_source", id_source[0], 7'h22);
    chk("in_d_data", id_data[0], ~pay(7'h22));
    chk_cnt(0, 4'd0, 4'd2);
    id_ready = 1'b1;
    step();
    @(negedge clock);
    chk("head_source", id_source[0], 7'h23);
    step();
    @(negedge clock);
    chk("drained_valid", id_valid[0], 1'b0);
    chk_cnt(0, 4'd0, 4'd0);

    // depth-1 FLOW: same-cycle pass-through, then a stalled beat lands in the store
    do_reset();
    ctx = "flow";
    set_a(1'b1, 7'h45);
    oa_ready = 1'b1;
    @(negedge clock);
    chk("out_a_valid", oa_valid[2], 1'b1);
    chk("out_a_source", oa_source[2], 7'h45);
    chk("out_a_address", oa_address[2], addr_of(7'h45));
    chk("in_a_ready", ia_ready[2], 1'b1);
    chk_cnt(2, 4'd0, 4'd0);
    step();
    set_a(1'b0, 7'h00);
    @(negedge clock);
    chk("after_flow_valid", oa_valid[2], 1'b0);
    chk_cnt(2, 4'd0, 4'd0);
    oa_ready = 1'b0;
    set_a(1'b1, 7'h46);
    #1;
    chk("flow_stall_valid", oa_valid[2], 1'b1);
    chk("flow_stall_source", oa_source[2], 7'h46);
    step();
    set_a(1'b0, 7'h00);
    @(negedge clock);
    chk("stored_valid", oa_valid[2], 1'b1);
    chk("stored_source", oa_source[2], 7'h46);
    chk("stored_data", oa_data[2], pay(7'h46));
    chk("full_in_ready", ia_ready[2], 1'b0);
    chk_cnt(2, 4'd1, 4'd0);
    oa_ready = 1'b1;
    step();
    @(negedge clock);
    chk("emptied_valid", oa_valid[2], 1'b0);

    // depth-3 stream at 50% out-ready: every beat once, in order
    do_reset();
    ctx = "stream3";
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    while (rcv < 10 && cyc < 200) begin
      set_a(sent < 10, 7'(sent + 1));
      oa_ready = (cyc % 2 == 1);
      @(negedge clock);
      if (oa_valid[1] && oa_ready) begin
        chk("beat_source", oa_source[1], 7'(rcv + 1));
        chk("beat_address", oa_address[1], addr_of(7'(rcv + 1)));
        rcv++;
      end
      if (a_valid && ia_ready[1]) sent++;
      step();
      cyc++;
    end
    chk("delivered", 64'(rcv), 64'd10);
    set_a(1'b0, 7'h00);
    oa_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("no_extra_beat", oa_valid[1], 1'b0);
      step();
    end
    chk_cnt(1, 4'd0, 4'd0);

    // reset mid-cycle with two queued beats discards them
    do_reset();
    ctx = "midreset";
    set_a(1'b1, 7'h03);
    step();
    set_a(1'b1, 7'h04);
    step();
    set_a(1'b0, 7'h00);
    @(negedge clock);
    chk("held_valid", oa_valid[0], 1'b1);
    chk_cnt(0, 4'd2, 4'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", oa_valid[0], 1'b0);
    chk("async_ready", ia_ready[0], 1'b1);
    chk_cnt(0, 4'd0, 4'd0);
    step();
    step();
    reset    = 1'b1;
    oa_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("stale_valid", oa_valid[0], 1'b0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
